// File: rtl/mips_core_pkg.sv
// Shared rename-stage constants and tag types: logical/physical register widths,
// map-table type and the lowest-set-bit helper used by the free list.
package mips_core_pkg;

  localparam int PHYS_REG_COUNT = 64;
  localparam int NUM_LOGICAL    = 32;
  localparam int PHYS_W         = $clog2(PHYS_REG_COUNT);
  localparam int LOG_W          = $clog2(NUM_LOGICAL);

  typedef logic [PHYS_W-1:0] PhysReg;
  typedef logic [LOG_W-1:0]  LogReg;
  typedef PhysReg [NUM_LOGICAL-1:0] map_t;

  // Descending scan so the last hit, i.e. the lowest set index, wins.
  function automatic PhysReg lowest_set(input logic [PHYS_REG_COUNT-1:0] vec);
    PhysReg idx;
    idx = '0;
    for (int i = PHYS_REG_COUNT - 1; i >= 0; i--) begin
      if (vec[i]) idx = PhysReg'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/reg_rename_unit_if.sv
// Decode/commit <-> rename bundle: rename request, registered issue outputs and
// the commit return path. The rename unit uses the slave modport.
interface reg_rename_unit_if;
  import mips_core_pkg::*;

  // Handshake: a request transfers on a cycle where req_valid && req_ready are
  // both high at the rising edge; req_ready never depends on req_valid. The
  // issue outputs are registered and reflect the transfer one cycle later.
  logic          req_valid;
  LogReg [1:0]   req_src_addr;
  logic          req_uses_rw;
  LogReg         req_rw_addr;
  logic          req_ready;

  logic          issue;
  LogReg [1:0]   logical_address;
  PhysReg [1:0]  physical_addr;
  PhysReg        issue_dst_phys;
  PhysReg        issue_old_phys;

  logic          commit_valid;
  LogReg         commit_logical;
  PhysReg        commit_phys;
  PhysReg        commit_old_phys;

  modport master (
    output req_valid, req_src_addr, req_uses_rw, req_rw_addr,
    output commit_valid, commit_logical, commit_phys, commit_old_phys,
    input  req_ready, issue, logical_address, physical_addr,
    input  issue_dst_phys, issue_old_phys
  );

  modport slave (
    input  req_valid, req_src_addr, req_uses_rw, req_rw_addr,
    input  commit_valid, commit_logical, commit_phys, commit_old_phys,
    output req_ready, issue, logical_address, physical_addr,
    output issue_dst_phys, issue_old_phys
  );

endinterface

// File: rtl/rename_free_list.sv
// Physical-register free vector: lowest-index allocation, commit-time release,
// and rebuild from the committed map on flush. Tag 0 is never free.
module rename_free_list
  import mips_core_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   alloc_en,
  input  logic   free_en,
  input  PhysReg free_tag,
  input  logic   rebuild,
  input  map_t   arch_map_next,
  output PhysReg alloc_tag,
  output logic   empty
);

  localparam logic [PHYS_REG_COUNT-1:0] RESET_VEC =
    {{(PHYS_REG_COUNT - NUM_LOGICAL){1'b1}}, {NUM_LOGICAL{1'b0}}};

  logic [PHYS_REG_COUNT-1:0] free_vec;
  logic [PHYS_REG_COUNT-1:0] free_vec_nxt;
  logic [PHYS_REG_COUNT-1:0] rebuild_vec;

  assign alloc_tag = lowest_set(free_vec);
  assign empty     = ~|free_vec;

  // Everything the committed map does not reference is free after a flush.
  always_comb begin
    rebuild_vec = '1;
    for (int i = 0; i < NUM_LOGICAL; i++) begin
      rebuild_vec[arch_map_next[i]] = 1'b0;
    end
    rebuild_vec[0] = 1'b0;
  end

  // Allocation reads the current vector, so a tag released this cycle only
  // becomes allocatable on the next one.
  always_comb begin
    free_vec_nxt = free_vec;
    if (alloc_en) free_vec_nxt[alloc_tag] = 1'b0;
    if (free_en && (free_tag != '0)) free_vec_nxt[free_tag] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      free_vec <= RESET_VEC;
    end else if (rebuild) begin
      free_vec <= rebuild_vec;
    end else begin
      free_vec <= free_vec_nxt;
    end
  end

endmodule

// File: rtl/reg_rename_unit.sv
// Register rename stage: speculative and committed map tables plus registered
// issue outputs. Optional full-stall counter under RENAME_PERF_CNT_EN.
module reg_rename_unit
  import mips_core_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic stall,
  input  logic flush,
  reg_rename_unit_if.slave rn
`ifdef RENAME_PERF_CNT_EN
  ,
  output logic [31:0] perf_full_stalls
`endif
);

  map_t   spec_map;
  map_t   arch_map;
  map_t   arch_map_next;
  logic   need_alloc;
  logic   fl_empty;
  logic   accept;
  PhysReg alloc_tag;

  assign need_alloc   = rn.req_uses_rw & (rn.req_rw_addr != '0);
  assign rn.req_ready = ~stall & ~flush & (~need_alloc | ~fl_empty);
  assign accept       = rn.req_valid & rn.req_ready;

  // Committed map including this cycle's retirement; flush restores from it.
  always_comb begin
    arch_map_next = arch_map;
    if (rn.commit_valid && (rn.commit_logical != '0)) begin
      arch_map_next[rn.commit_logical] = rn.commit_phys;
    end
  end

  rename_free_list u_free_list (
    .clk           (clk),
    .rst           (rst),
    .alloc_en      (accept & need_alloc),
    .free_en       (rn.commit_valid),
    .free_tag      (rn.commit_old_phys),
    .rebuild       (flush),
    .arch_map_next (arch_map_next),
    .alloc_tag     (alloc_tag),
    .empty         (fl_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_LOGICAL; i++) begin
        spec_map[i] <= PhysReg'(i);
        arch_map[i] <= PhysReg'(i);
      end
      rn.issue           <= 1'b0;
      rn.logical_address <= '0;
      rn.physical_addr   <= '0;
      rn.issue_dst_phys  <= '0;
      rn.issue_old_phys  <= '0;
    end else begin
      arch_map <= arch_map_next;
      if (flush) begin
        spec_map <= arch_map_next;
        rn.issue <= 1'b0;
      end else if (stall) begin
        rn.issue <= rn.issue;
      end else if (accept) begin
        rn.issue              <= 1'b1;
        rn.logical_address    <= rn.req_src_addr;
        // Sources see the mapping before this instruction's own dest update.
        rn.physical_addr[0]   <= spec_map[rn.req_src_addr[0]];
        rn.physical_addr[1]   <= spec_map[rn.req_src_addr[1]];
        if (need_alloc) begin
          rn.issue_dst_phys         <= alloc_tag;
          rn.issue_old_phys         <= spec_map[rn.req_rw_addr];
          spec_map[rn.req_rw_addr]  <= alloc_tag;
        end else begin
          rn.issue_dst_phys <= '0;
          rn.issue_old_phys <= '0;
        end
      end else begin
        rn.issue <= 1'b0;
      end
    end
  end

`ifdef RENAME_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_full_stalls <= '0;
    end else if (rn.req_valid && need_alloc && fl_empty && !stall &&
                 (perf_full_stalls != 32'hFFFF_FFFF)) begin
      perf_full_stalls <= perf_full_stalls + 32'd1;
    end
  end
`endif

endmodule
